// File: rtl/nibble_serial_adder_ctl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer and its 4-bit slice.
package nibble_serial_adder_ctl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctl_add4_slice.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder slice.
module add4_slice
    import nibble_serial_adder_ctl_pkg::*;
(
    input  logic                c0_i,
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c4_o
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is flattened from c0 so no carry ripples inside the slice.
    assign c[0] = c0_i;
    assign c[1] = g[0] | (p[0] & c0_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0_i);

    assign s_o  = p ^ c[NIBBLE_W-1:0];
    assign c4_o = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctl.sv
// Sequencer that computes one WIDTH-bit add/subtract by passing one nibble per
// cycle through a shared 4-bit lookahead slice, LS nibble first.
module nibble_serial_adder_ctl
    import nibble_serial_adder_ctl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] sliceS;
    logic                sliceC4;
    logic [WIDTH-1:0]    loadB;

    // Operands shift right each pass, so the slice always sees the low nibble.
    add4_slice u_slice (
        .c0_i (carry_q),
        .a_i  (opA_q[NIBBLE_W-1:0]),
        .b_i  (opB_q[NIBBLE_W-1:0]),
        .s_o  (sliceS),
        .c4_o (sliceC4)
    );

    assign loadB = sub_i ? ~b_i : b_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        signA_d = signA_q;
        signB_d = signB_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    state_d = RUN;
                    opA_d   = a_i;
                    opB_d   = loadB;
                    carry_d = sub_i | cin_i;
                    count_d = '0;
                    signA_d = a_i[WIDTH-1];
                    signB_d = loadB[WIDTH-1];
                end
            end
            RUN: begin
                sum_d[{count_q, 2'b00} +: NIBBLE_W] = sliceS;
                carry_d = sliceC4;
                opA_d   = opA_q >> NIBBLE_W;
                opB_d   = opB_q >> NIBBLE_W;
                count_d = count_q + CNT_W'(1);
                // The top carry only reaches cout; it never wraps into nibble 0.
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                    count_d = '0;
                    cout_d  = sliceC4;
                    ovf_d   = (signA_q == signB_q) && (sliceS[NIBBLE_W-1] != signA_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE) || (state_q == DONE);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctl.sv
// Randomised self-checking bench for nibble_serial_adder_ctl at WIDTH 32 and 8.
module tb_nibble_serial_adder_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, sub32, cin32;
    logic [31:0] a32, b32;
    logic        ready32, busy32, done32, cout32, ovf32;
    logic [31:0] sum32;
    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        ready8, busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctl #(.WIDTH(32)) dut32 (
        .clk_i(clk), .reset_i(reset), .start_i(start32), .sub_i(sub32), .cin_i(cin32),
        .a_i(a32), .b_i(b32), .ready_o(ready32), .busy_o(busy32), .done_o(done32),
        .sum_o(sum32), .cout_o(cout32), .ovf_o(ovf32)
    );

    nibble_serial_adder_ctl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(reset), .start_i(start8), .sub_i(sub8), .cin_i(cin8),
        .a_i(a8), .b_i(b8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
        .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: plain integer arithmetic, with overflow judged on true signed values.
    function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic s, input logic c, output logic [31:0] sum,
                                     output logic co, output logic ov);
        longint unsigned mask, au, bu, u;
        longint half, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        au   = a & mask;
        bu   = b & mask;
        u    = s ? (au + (mask - bu) + 64'd1) : (au + bu + (c ? 64'd1 : 64'd0));
        sum  = 32'(u & mask);
        co   = ((u >> w) & 64'd1) != 0;
        half = longint'(64'd1 << (w - 1));
        sa   = (au >= 64'(half)) ? longint'(au) - 2 * half : longint'(au);
        sb   = (bu >= 64'(half)) ? longint'(bu) - 2 * half : longint'(bu);
        sr   = s ? (sa - sb) : (sa + sb + (c ? 1 : 0));
        ov   = (sr >= half) || (sr < -half);
    endfunction

    task automatic driveIn(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic c);
        if (w == 32) begin
            start32 = st; a32 = a; b32 = b; sub32 = s; cin32 = c;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = s; cin8 = c;
        end
    endtask

    function automatic logic [34:0] outsOf(input int w);
        if (w == 32) return {ready32, busy32, done32, sum32};
        return {ready8, busy8, done8, 24'd0, sum8};
    endfunction

    function automatic logic [1:0] flagsOf(input int w);
        if (w == 32) return {cout32, ovf32};
        return {cout8, ovf8};
    endfunction

    // One operation: accept, scramble inputs and pulse start during RUN, then check.
    task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic c);
        logic [31:0] expSum;
        logic        expCout, expOvf;
        int          lat, busyCnt;
        refModel(w, a, b, s, c, expSum, expCout, expOvf);
        @(negedge clk);
        checkOutput($sformatf("w%0d_ready_before", w), 64'(outsOf(w)[34]), 64'd1);
        driveIn(w, 1'b1, a, b, s, c);
        @(negedge clk);
        lat = 1;
        busyCnt = 0;
        while (!outsOf(w)[32] && lat < 40) begin
            if (outsOf(w)[33]) busyCnt++;
            driveIn(w, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            lat++;
        end
        driveIn(w, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
        checkOutput($sformatf("w%0d_latency", w), 64'(lat), 64'(w / 4 + 1));
        checkOutput($sformatf("w%0d_busy_cycles", w), 64'(busyCnt), 64'(w / 4));
        checkOutput($sformatf("w%0d_sum", w), 64'(outsOf(w)[31:0]), 64'(expSum));
        checkOutput($sformatf("w%0d_cout", w), 64'(flagsOf(w)[1]), 64'(expCout));
        checkOutput($sformatf("w%0d_ovf", w), 64'(flagsOf(w)[0]), 64'(expOvf));
        @(negedge clk);
        checkOutput($sformatf("w%0d_done_pulse", w), 64'(outsOf(w)[32]), 64'd0);
    endtask

    task automatic sweep(input int w, input int ops);
        for (int i = 0; i < ops; i++)
            applyStimulus(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [31:0] qa[45], qb[45];
        logic        qs[45], qc[45];
        logic [31:0] expSum;
        logic        expCout, expOvf, expDone, sawDone;

        reset = 1'b1;
        driveIn(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        driveIn(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_outs32", 64'(outsOf(32)), {29'd0, 3'b100, 32'd0});
        checkOutput("reset_flags32", 64'(flagsOf(32)), 64'd0);
        checkOutput("reset_outs8", 64'(outsOf(8)), {29'd0, 3'b100, 32'd0});
        reset = 1'b0;

        applyStimulus(32, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        applyStimulus(32, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        applyStimulus(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        applyStimulus(8, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(8, 32'h0000_0080, 32'h0000_0001, 1'b1, 1'b0);

        // Start held high: an accept every 9 edges, operands sampled at each accept.
        for (int i = 0; i < 45; i++) begin
            qa[i] = $urandom;
            qb[i] = $urandom;
            qs[i] = 1'($urandom_range(0, 1));
            qc[i] = 1'($urandom_range(0, 1));
            driveIn(32, 1'b1, qa[i], qb[i], qs[i], qc[i]);
            @(negedge clk);
            expDone = (i % 9 == 8);
            checkOutput("b2b_done", 64'(done32), 64'(expDone));
            if (expDone) begin
                refModel(32, qa[i-8], qb[i-8], qs[i-8], qc[i-8], expSum, expCout, expOvf);
                checkOutput("b2b_sum", 64'(sum32), 64'(expSum));
                checkOutput("b2b_flags", 64'({cout32, ovf32}), 64'({expCout, expOvf}));
            end
        end
        driveIn(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Abort in the 4th RUN cycle.
        driveIn(32, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        driveIn(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_outs", 64'(outsOf(32)), {29'd0, 3'b100, 32'd0});
        checkOutput("abort_flags", 64'(flagsOf(32)), 64'd0);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done32) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 64'(sawDone), 64'd0);
        applyStimulus(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        // Reset and start together: start must be dropped.
        reset = 1'b1;
        driveIn(32, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        driveIn(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("rst_start_busy", 64'(busy32), 64'd0);
        @(negedge clk);
        checkOutput("rst_start_dropped", 64'(busy32), 64'd0);

        fork
            sweep(32, 4000);
            sweep(8, 6000);
        join

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
